// File: rtl/fp_add_scheduler.sv
// rtl/fp_add_scheduler.sv - round-robin scheduler sharing one FP adder among NREQ requesters
module fp_add_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*32-1:0]       req_a,
  input  logic [NREQ*32-1:0]       req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     add_start,
  output logic [31:0]              add_a,
  output logic [31:0]              add_b,
  input  logic                     add_done,
  input  logic [31:0]              add_result,
  output logic                     resp_valid,
  output logic [$clog2(NREQ)-1:0]  resp_id,
  output logic [31:0]              resp_result,
  output logic                     resp_err,
  input  logic                     resp_ready,
  output logic                     busy
);

  localparam int          IDW  = $clog2(NREQ);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_owner;
  logic [7:0]      r_wait_cnt;
  logic [31:0]     r_op_a;
  logic [31:0]     r_op_b;
  logic [31:0]     r_result;
  logic            r_err;

  logic            w_grant_vld;
  logic [IDW-1:0]  w_grant_idx;
  logic [IDW-1:0]  w_idx;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // First pending requester at or above the pointer, wrapping around.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = wrap_add(r_rr_ptr, k);
      if (!w_grant_vld && req_valid[w_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_grant_vld) req_ready[w_grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_wait_cnt <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_owner <= w_grant_idx;
            r_op_a  <= req_a[32*w_grant_idx +: 32];
            r_op_b  <= req_b[32*w_grant_idx +: 32];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wait_cnt <= '0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last wait cycle still returns the real result.
          if (add_done) begin
            r_result <= add_result;
            r_err    <= 1'b0;
            r_state  <= S_RESP;
          end else if (r_wait_cnt == 8'(TIMEOUT-1)) begin
            r_result <= QNAN;
            r_err    <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_rr_ptr <= wrap_add(r_owner, 1);
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign add_start   = (r_state == S_ISSUE);
  assign add_a       = r_op_a;
  assign add_b       = r_op_b;
  assign resp_valid  = (r_state == S_RESP);
  assign resp_id     = r_owner;
  assign resp_result = r_result;
  assign resp_err    = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_fp_add_scheduler.sv
// tb/tb_fp_add_scheduler.sv - scoreboard bench for fp_add_scheduler
module tb_fp_add_scheduler;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_a = '0;
  logic [127:0] req_b = '0;
  logic [3:0]   req_ready;
  logic         add_start;
  logic [31:0]  add_a, add_b;
  logic         add_done = 1'b0;
  logic [31:0]  add_result;
  logic         resp_valid;
  logic [1:0]   resp_id;
  logic [31:0]  resp_result;
  logic         resp_err;
  logic         resp_ready = 1'b0;
  logic         busy;

  fp_add_scheduler #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_result(add_result), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_result(resp_result), .resp_err(resp_err),
    .resp_ready(resp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          m_ptr = 0;
  int          model_delay = 0;
  int          mcnt = 0;
  logic [31:0] model_res = '0;

  assign add_result = model_res;

  // Adder model: add_done pulses model_delay cycles after add_start (0 = never).
  always @(negedge clk) begin
    add_done = 1'b0;
    if (mcnt > 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) add_done = 1'b1;
    end
    if (add_start && model_delay > 0) mcnt = model_delay;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic do_txn(input logic [3:0] v, input int delay, input logic [31:0] res,
                        input bit use_xor, input int hold);
    int          g;
    int          lat;
    bit          seen;
    exp_t        e;
    exp_t        got;
    logic [31:0] opa, opb;
    g     = model_grant(v, m_ptr);
    opa   = req_a[32*g +: 32];
    opb   = req_b[32*g +: 32];
    model_res = use_xor ? (opa ^ opb) : res;
    e.id  = 2'(g);
    e.err = (delay == 0) || (delay > TIMEOUT);
    e.res = e.err ? 32'h7FC0_0000 : model_res;
    sb.push_back(e);
    model_delay = delay;
    req_valid   = v;
    #1;
    chk("grant_onehot", 32'(req_ready), 32'd1 << g);
    lat  = e.err ? TIMEOUT + 2 : delay + 2;
    seen = 1'b0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk); #1;
      chk("no_grant_busy", 32'(req_ready), 32'd0);
      if (c == 1) begin
        chk("add_start", 32'(add_start), 32'd1);
        chk("add_a", add_a, opa);
        chk("add_b", add_b, opb);
      end
      if (c == 2) chk("add_start_1cyc", 32'(add_start), 32'd0);
      if (resp_valid) begin
        seen = 1'b1;
        chk("resp_latency", c, lat);
      end
    end
    if (!seen) begin
      chk("resp_seen", 32'd0, 32'd1);
      req_valid = '0;
      return;
    end
    got = sb.pop_front();
    chk("resp_id", 32'(resp_id), 32'(got.id));
    chk("resp_result", resp_result, got.res);
    chk("resp_err", 32'(resp_err), 32'(got.err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_id", 32'(resp_id), 32'(got.id));
      chk("hold_result", resp_result, got.res);
      chk("hold_err", 32'(resp_err), 32'(got.err));
      chk("hold_add_a", add_a, opa);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    resp_ready = 1'b0;
    chk("valid_drop", 32'(resp_valid), 32'd0);
    chk("idle_after_hs", 32'(busy), 32'd0);
    m_ptr     = (g + 1) % NREQ;
    req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = 32'h3F80_0000 + 32'h0011_0000 * i;
      req_b[32*i +: 32] = 32'h4000_0000 + 32'h0000_0123 * (i + 1);
    end
    @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_add_start", 32'(add_start), 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_resp_result", resp_result, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Fairness: all four requesting, grant order follows the rotating pointer.
    do_txn(4'b1111, 1, '0, 1'b1, 0);
    do_txn(4'b1111, 2, '0, 1'b1, 0);
    do_txn(4'b1111, 3, '0, 1'b1, 0);
    do_txn(4'b1111, 1, '0, 1'b1, 0);
    do_txn(4'b1111, 5, '0, 1'b1, 0);

    req_a[95:64] = 32'h3F80_0000;
    req_b[95:64] = 32'h4000_0000;
    do_txn(4'b0100, 2, 32'h4040_0000, 1'b0, 0);
    do_txn(4'b0011, 0, '0, 1'b1, 0);
    do_txn(4'b1000, TIMEOUT, 32'hC0A0_0000, 1'b0, 0);
    // Done arrives one cycle into RESP and must not disturb the held timeout response.
    do_txn(4'b0010, TIMEOUT + 1, 32'h1234_5678, 1'b0, 10);

    model_res   = 32'h1111_1111;
    model_delay = 8;
    req_valid   = 4'b1000;
    #1;
    chk("rst_txn_grant", 32'(req_ready), 32'd1 << model_grant(4'b1000, m_ptr));
    repeat (3) @(negedge clk);
    #1;
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_add_a", add_a, 32'd0);
    chk("mid_rst_add_b", add_b, 32'd0);
    chk("mid_rst_resp_result", resp_result, 32'd0);
    chk("mid_rst_resp_err", 32'(resp_err), 32'd0);
    chk("mid_rst_resp_id", 32'(resp_id), 32'd0);
    chk("mid_rst_add_start", 32'(add_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk); #1;
      chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
      chk("post_rst_idle", 32'(busy), 32'd0);
    end
    do_txn(4'b1111, 1, '0, 1'b1, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
